// File: rtl/vga_text_render.sv
`timescale 1ns/1ps
// vga_text_render
//   Text-mode pixel renderer for an 800x600 raster built from 8x16 glyph cells.
//   A three-stage fetch pipeline (text RAM -> font ROM -> glyph bit) plus an
//   output register turns the timing stage's hc/vc into an RGB332 pixel, with a
//   blinking underline cursor. Syncs and vidon travel alongside in shift chains.
//
// Ports
//   clk, clr               pixel clock, synchronous active-high reset
//   hc, vc                 horizontal / vertical counters from the timing stage
//   vidon                  active-video flag
//   hsync_i, vsync_i       raw syncs from the timing stage
//   tram_addr / tram_data  text RAM word address (registered) / word read back
//   font_addr / font_data  font ROM address {char, glyph_row} / glyph row bits
//   bg_color               global background colour (RGB332)
//   cur_en, cur_col, cur_row  cursor enable and cell position
//   red, green, blue       registered pixel colour
//   hsync_o, vsync_o       syncs aligned with the colour outputs
module vga_text_render #(
    parameter int COLS       = 100,
    parameter int ROWS       = 37,
    parameter int BLINK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [11:0] hc,
    input  logic [11:0] vc,
    input  logic        vidon,
    input  logic        hsync_i,
    input  logic        vsync_i,
    output logic [11:0] tram_addr,
    input  logic [15:0] tram_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [7:0]  bg_color,
    input  logic        cur_en,
    input  logic [6:0]  cur_col,
    input  logic [5:0]  cur_row,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        hsync_o,
    output logic        vsync_o
);

    function automatic logic [7:0] pick_colour(input logic vld, input logic oob,
                                               input logic pix, input logic cur,
                                               input logic [7:0] fg,
                                               input logic [7:0] bg);
        if (!vld)
            return 8'h00;
        if (oob)
            return bg;
        if (pix || cur)
            return fg;
        return bg;
    endfunction

    logic [6:0]  col;
    logic [2:0]  gx;
    logic [5:0]  row;
    logic [3:0]  gr;
    logic [11:0] row_ext;
    logic [11:0] cell_addr;
    logic        cell_oob;
    logic        cur_valid;
    logic        cur_hit;
    logic        unused_bits;

    logic [BLINK_LOG2:0] frame_cnt;

    logic       vld_p0, vld_p1, vld_p2;
    logic       hs_p0, hs_p1, hs_p2;
    logic       vs_p0, vs_p1, vs_p2;
    logic [7:0] rgb_q;

    logic [3:0] gr_p0;
    logic [2:0] gx_p0, gx_p1;
    logic       oob_p0, oob_p1, oob_p2;
    logic       cur_p0, cur_p1, cur_p2;
    logic [7:0] fg_p1, fg_p2;
    logic       pix_p2;

    assign col = hc[9:3];
    assign gx  = hc[2:0];
    assign row = vc[9:4];
    assign gr  = vc[3:0];
    assign unused_bits = ^{hc[11:10], vc[11:10]};

    // row*100 + col as row*64 + row*32 + row*4 + col, kept to 12 bits
    assign row_ext   = {6'b0, row};
    assign cell_addr = (row_ext << 6) + (row_ext << 5) + (row_ext << 2) + {5'b0, col};

    assign cell_oob  = (32'(row) >= ROWS) || (32'(col) >= COLS);
    assign cur_valid = (32'(cur_row) < ROWS) && (32'(cur_col) < COLS);
    // underline cursor: last two glyph rows of the cursor cell, during blink-on phase
    assign cur_hit   = cur_en && frame_cnt[BLINK_LOG2] && cur_valid &&
                       (row == cur_row) && (col == cur_col) && (gr[3:1] == 3'b111);

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            hs_p0     <= 1'b1;
            hs_p1     <= 1'b1;
            hs_p2     <= 1'b1;
            vs_p0     <= 1'b1;
            vs_p1     <= 1'b1;
            vs_p2     <= 1'b1;
            hsync_o   <= 1'b1;
            vsync_o   <= 1'b1;
            frame_cnt <= '0;
            tram_addr <= 12'd0;
            font_addr <= 12'd0;
            rgb_q     <= 8'h00;
        end else begin
            // stage 1: cell address out to text RAM
            vld_p0    <= vidon;
            hs_p0     <= hsync_i;
            vs_p0     <= vsync_i;
            tram_addr <= cell_addr;
            if (hc == 12'd0 && vc == 12'd0)
                frame_cnt <= frame_cnt + {{BLINK_LOG2{1'b0}}, 1'b1};
            // stage 2: character code out to font ROM
            vld_p1    <= vld_p0;
            hs_p1     <= hs_p0;
            vs_p1     <= vs_p0;
            font_addr <= {tram_data[7:0], gr_p0};
            // stage 3: glyph bit picked (data path below)
            vld_p2    <= vld_p1;
            hs_p2     <= hs_p1;
            vs_p2     <= vs_p1;
            // output: colour and syncs leave together
            hsync_o   <= hs_p2;
            vsync_o   <= vs_p2;
            rgb_q     <= pick_colour(vld_p2, oob_p2, pix_p2, cur_p2, fg_p2, bg_color);
        end
    end

    always_ff @(posedge clk) begin
        // stage 1
        gr_p0  <= gr;
        gx_p0  <= gx;
        oob_p0 <= cell_oob;
        cur_p0 <= cur_hit;
        // stage 2
        gx_p1  <= gx_p0;
        oob_p1 <= oob_p0;
        cur_p1 <= cur_p0;
        fg_p1  <= tram_data[15:8];
        // stage 3
        pix_p2 <= font_data[3'd7 - gx_p1];
        oob_p2 <= oob_p1;
        cur_p2 <= cur_p1;
        fg_p2  <= fg_p1;
    end

    assign red   = rgb_q[7:5];
    assign green = rgb_q[4:2];
    assign blue  = rgb_q[1:0];

endmodule

// File: tb/tb_vga_text_render.sv
`timescale 1ns/1ps
module tb_vga_text_render;

    localparam int COLS = 100;
    localparam int ROWS = 37;
    localparam int BLINK_LOG2 = 5;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [11:0] hc = '0, vc = '0;
    logic        vidon = 1'b0, hsync_i = 1'b1, vsync_i = 1'b1;
    logic [11:0] tram_addr, font_addr;
    logic [15:0] tram_data;
    logic [7:0]  font_data;
    logic [7:0]  bg_color = 8'h00;
    logic        cur_en = 1'b0;
    logic [6:0]  cur_col = '0;
    logic [5:0]  cur_row = '0;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        hsync_o, vsync_o;

    logic [15:0] tram_mem [4096];
    logic [7:0]  font_mem [4096];

    // memories present data in the clock after their address is registered
    assign tram_data = tram_mem[tram_addr];
    assign font_data = font_mem[font_addr];

    vga_text_render #(.COLS(COLS), .ROWS(ROWS), .BLINK_LOG2(BLINK_LOG2)) dut (
        .clk(clk), .clr(clr), .hc(hc), .vc(vc), .vidon(vidon),
        .hsync_i(hsync_i), .vsync_i(vsync_i),
        .tram_addr(tram_addr), .tram_data(tram_data),
        .font_addr(font_addr), .font_data(font_data),
        .bg_color(bg_color), .cur_en(cur_en), .cur_col(cur_col), .cur_row(cur_row),
        .red(red), .green(green), .blue(blue),
        .hsync_o(hsync_o), .vsync_o(vsync_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] colour;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   fc = 0;
    int   prev_addr = 0;
    int   prev_gr = 0;
    bit   prev_rst = 1'b1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cell_of(input int h, input int v);
        return (((v / 16) % 64) * 100 + ((h / 8) % 128)) % 4096;
    endfunction

    // pixel colour straight from the text-mode rules
    function automatic logic [7:0] model_colour(input int h, input int v, input bit vid);
        int row, col, gy, gxx, w, ch, bits;
        bit pix, cur;
        if (!vid)
            return 8'h00;
        row = (v / 16) % 64;
        col = (h / 8) % 128;
        if (row >= ROWS || col >= COLS)
            return bg_color;
        w    = int'(tram_mem[cell_of(h, v)]);
        ch   = w % 256;
        gy   = v % 16;
        gxx  = h % 8;
        bits = int'(font_mem[ch * 16 + gy]);
        pix  = ((bits >> (7 - gxx)) % 2) == 1;
        cur  = cur_en && (((fc >> BLINK_LOG2) % 2) == 1) &&
               (int'(cur_row) < ROWS) && (int'(cur_col) < COLS) &&
               (row == int'(cur_row)) && (col == int'(cur_col)) && (gy >= 14);
        return (pix || cur) ? 8'(w / 256) : bg_color;
    endfunction

    task automatic step(input int h, input int v, input bit vid, input bit hs,
                        input bit vs, input bit rst);
        exp_t e;
        hc = 12'(h);
        vc = 12'(v);
        vidon = vid;
        hsync_i = hs;
        vsync_i = vs;
        clr = rst;
        if (rst) begin
            // everything still in flight is wiped by the reset
            for (int i = 0; i < q.size(); i++) q[i] = '{8'h00, 1'b1, 1'b1};
            q.push_back('{8'h00, 1'b1, 1'b1});
            fc = 0;
        end else begin
            e.colour = model_colour(h, v, vid);
            e.hs = hs;
            e.vs = vs;
            q.push_back(e);
            if (h == 0 && v == 0) fc++;
        end
        @(posedge clk);
        @(negedge clk);
        if (rst) begin
            check("tram_addr_rst", 16'(tram_addr), 16'd0);
            check("font_addr_rst", 16'(font_addr), 16'd0);
        end else begin
            check("tram_addr", 16'(tram_addr), 16'(cell_of(h, v)));
            if (!prev_rst)
                check("font_addr", 16'(font_addr),
                      16'({tram_mem[prev_addr][7:0], 4'(prev_gr)}));
        end
        prev_rst = rst;
        prev_addr = cell_of(h, v);
        prev_gr = v % 16;
        if (q.size() == 4) begin
            e = q.pop_front();
            check("colour", 16'({red, green, blue}), 16'(e.colour));
            check("hsync_o", 16'(hsync_o), 16'(e.hs));
            check("vsync_o", 16'(vsync_o), 16'(e.vs));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1000, 610, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        int h, v, lowcnt;
        bit vid;
        for (int i = 0; i < 4096; i++) begin
            tram_mem[i] = 16'($urandom);
            font_mem[i] = 8'($urandom);
        end
        @(negedge clk);

        // reset state
        for (int i = 0; i < 3; i++) step(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("red_rst", 16'(red), 16'd0);
        check("hsync_rst", 16'(hsync_o), 16'd1);

        // directed cell (row 1, col 1): lit glyph bit, then unlit neighbour
        bg_color = 8'h03;
        tram_mem[101] = 16'hE041;
        font_mem[12'h410] = 8'h80;
        step(8, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        check("tram_addr_101", 16'(tram_addr), 16'd101);
        step(9, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        check("font_addr_410", 16'(font_addr), 16'h0410);
        step(10, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        step(11, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        check("req034_colour", 16'({red, green, blue}), 16'h00E0);
        step(12, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        check("req035_colour", 16'({red, green, blue}), 16'h0003);
        idle(4);

        // blanked video with a fully lit glyph and a 120-clock hsync pulse
        for (int i = 0; i < 256; i++) font_mem[i * 16 + 5] = 8'hFF;
        for (int i = 0; i < 4; i++) step(i, 5, 1'b0, 1'b1, 1'b1, 1'b0);
        lowcnt = 0;
        for (int i = 0; i < 128; i++) begin
            step(100 + i, 5, 1'b0, (i >= 120), 1'b1, 1'b0);
            if (hsync_o == 1'b0) lowcnt++;
        end
        check("hsync_width", 16'(lowcnt), 16'd120);

        // blinking cursor at cell (row 1, col 2)
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        cur_en = 1'b1;
        cur_col = 7'd2;
        cur_row = 6'd1;
        tram_mem[102] = 16'h1C05;
        for (int i = 0; i < 16; i++) font_mem[16 * 5 + i] = 8'h00;
        for (int f = 0; f < 3; f++) begin
            for (int y = 29; y <= 31; y++)
                for (int x = 14; x <= 25; x++) step(x, y, 1'b1, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 32; i++) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        cur_col = 7'd120;
        for (int x = 16; x < 24; x++) step(x, 30, 1'b1, 1'b1, 1'b1, 1'b0);
        cur_en = 1'b0;

        // bottom band and right-hand columns outside the text grid
        for (int x = 0; x < 800; x++) step(x, 595, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int x = 800; x < 1024; x += 8) step(x, 100, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);

        // randomized raster positions, cursor settings and a mid-frame reset
        bg_color = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            h = $urandom_range(0, 1055);
            v = $urandom_range(0, 627);
            if ($urandom_range(0, 19) == 0) begin
                h = 0;
                v = 0;
            end
            vid = (h < 800 && v < 600) ? ($urandom_range(0, 7) != 0) : 1'b0;
            cur_en = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                cur_row = 6'((v / 16) % 64);
                cur_col = 7'((h / 8) % 128);
            end else begin
                cur_row = 6'($urandom);
                cur_col = 7'($urandom);
            end
            step(h, v, vid, 1'($urandom), 1'($urandom), (n == 1500));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/vga_text_render.md
VGA_TEXT_RENDER -- requirements
Module: vga_text_render

Interface
REQ-001 Parameter COLS, default 100, text columns per row (800 px / 8 px glyph width).
REQ-002 Parameter ROWS, default 37, text rows (600 px / 16 px glyph height, truncated).
REQ-003 Parameter BLINK_LOG2, default 5, cursor blink half-period is 2^BLINK_LOG2 frames.
REQ-004 clk  in  1  pixel clock, 40 MHz; all logic on rising edge.
REQ-005 clr  in  1  reset, synchronous, active-high.
REQ-006 hc  in  12  horizontal pixel counter from the VGA timing stage.
REQ-007 vc  in  12  vertical line counter from the VGA timing stage.
REQ-008 vidon  in  1  active-video flag from the timing stage.
REQ-009 hsync_i / vsync_i  in  1 each  raw syncs from the timing stage.
REQ-010 tram_addr  out  12  text RAM word address, registered.
REQ-011 tram_data  in  16  text RAM word: [7:0] char code, [15:8] foreground RGB332; valid one clock after tram_addr.
REQ-012 font_addr  out  12  font ROM address {char[7:0], glyph_row[3:0]}, registered.
REQ-013 font_data  in  8  glyph row bits, bit 7 = leftmost pixel; valid one clock after font_addr.
REQ-014 bg_color  in  8  global background RGB332.
REQ-015 cur_en  in  1  cursor enable.
REQ-016 cur_col / cur_row  in  7 / 6  cursor cell position.
REQ-017 red out 3, green out 3, blue out 2  registered pixel colour (RGB332 split).
REQ-018 hsync_o / vsync_o  out  1 each  syncs delayed to align with colour.

Function
REQ-019 col = hc[9:3], glyph_x = hc[2:0], row = vc[9:4], glyph_row = vc[3:0].
REQ-020 Stage 1 (edge k): tram_addr <= row*100 + col, computed shift-add (row<<6 + row<<5 + row<<2 + col), 12-bit, no multiplier.
REQ-021 Stage 2 (edge k+1): font_addr <= {tram_data[7:0], glyph_row delayed 1}; fg colour and control bits also registered.
REQ-022 Stage 3 (edge k+2): pixel bit = font_data[7 - glyph_x delayed 2].
REQ-023 Output (edge k+3): colour <= fg if pixel bit or cursor pixel, else bg_color; total latency hc/vc -> red/green/blue exactly 3 clocks.
REQ-024 vidon, hsync_i, vsync_i each delayed through a 3-register shift chain so hsync_o/vsync_o align with colour.
REQ-025 Colour output forced to 0 when delayed vidon = 0.
REQ-026 Colour forced to bg_color when row >= ROWS or col >= COLS during active video (vc 592..599 blank rows); tram_addr still updated but data ignored.
REQ-027 Frame counter (BLINK_LOG2+1 bits) increments by 1 on the clock where hc == 0 and vc == 0; wraps modulo 2^(BLINK_LOG2+1).
REQ-028 Blink phase = frame counter MSB; cursor visible when cur_en = 1 and phase = 1.
REQ-029 Cursor pixel = visible and (row, col) == (cur_row, cur_col) and glyph_row in {14, 15}; decision pipelined with the pixel path.
REQ-030 cur_col >= COLS or cur_row >= ROWS: no cursor drawn, no other effect.
REQ-031 Inputs sampled every clock; no stall or back-pressure; memory latencies are fixed at 1 clock.

Reset
REQ-032 On clr = 1 at a rising edge: red/green/blue <= 0, hsync_o <= 1, vsync_o <= 1, all delay-chain vidon bits <= 0, sync chains <= 1, frame counter <= 0, tram_addr <= 0, font_addr <= 0.
REQ-033 Reset mid-frame: outputs hold reset values while clr = 1; first valid colour 3 clocks after clr deasserts, with vidon chain refilling from 0.

Verification
REQ-034 hc=8, vc=16, tram_data=0xE041, font_data=0x80, bg_color=0x03 -> 3 clocks later colour = 0xE0 (red=7, green=0, blue=0); tram_addr was 101, font_addr 0x410.
REQ-035 Same cell, hc=9 (glyph_x=1), font_data=0x80 -> colour = 0x03 (bg).
REQ-036 vidon=0 with font_data=0xFF -> colour 0 three clocks later; hsync_i pulse of 120 clocks reappears on hsync_o delayed exactly 3 clocks, same width.
REQ-037 cur_en=1, cur_col=2, cur_row=1, font_data=0x00, fg=0x1C: frames 0..31 -> no cursor at vc=30; frames 32..63 -> colour 0x1C on hc 16..23, vc 30..31.
REQ-038 vc=595 (row 37), hc=0..799, any tram_data -> colour = bg_color for every pixel.
REQ-039 Assert clr for 1 clock during active video -> next edge colour 0, hsync_o=1, vsync_o=1, frame counter 0; valid pixels resume 3 clocks after release.
